// File: rtl/pad_arb_pkg.sv
// -----------------------------------------------------------------------------
// pad_arb_pkg
// Shared types and helpers for the pad bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, TURN)
//   idx_w()     : width of an index into n requesters (never less than 1 bit)
// -----------------------------------------------------------------------------
package pad_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // Index width for n requesters. $clog2(1) would be 0, which cannot form a
  // legal vector, so clamp to one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. It searches upward from
// last_owner+1, wrapping around, and returns the first asserted request.
//
// Ports:
//   req        in  NUM_REQ : request vector
//   last_owner in  IDX_W   : index of the most recent owner
//   any        out 1       : at least one request is asserted
//   pick       out IDX_W   : chosen requester (0 when any = 0)
// -----------------------------------------------------------------------------
module rr_pick
  import pad_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               any,
  output logic [IDX_W-1:0]   pick
);

  // Index that lies k places above 'last', modulo NUM_REQ. last < NUM_REQ
  // and k <= NUM_REQ, so a single conditional subtract replaces a divider.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] last,
                                                input int unsigned      k);
    int unsigned sum;
    sum = int'(last) + k;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  logic w_found;

  // NOTE: every signal assigned in always_comb receives a default first, so no
  // path through the block can leave it holding its old value (a latch).
  always_comb begin
    any     = |req;
    pick    = '0;
    w_found = 1'b0;
    // Nearest candidate is k = 1; the owner itself (k = NUM_REQ) is last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req[wrap_idx(last_owner, k)]) begin
        pick    = wrap_idx(last_owner, k);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pad_arbiter.sv
// -----------------------------------------------------------------------------
// pad_arbiter
// Round-robin owner selection for the shared bidirectional pad bus. One
// requester owns the bus at a time, for at most MAX_HOLD consecutive cycles,
// and every change of ownership passes through a one-cycle TURN with all
// output enables off, so two drivers never overlap on the pads.
//
// Parameters:
//   NUM_REQ  (>= 2) : number of requesters
//   WIDTH           : pad bus width
//   MAX_HOLD (>= 1) : maximum consecutive grant cycles per ownership
//
// Ports:
//   clk       in  1             : clock
//   rst_n     in  1             : asynchronous active-low reset
//   req       in  NUM_REQ       : level-sensitive request per requester
//   req_data  in  NUM_REQ*WIDTH : requester i drives [i*WIDTH +: WIDTH]
//   gnt       out NUM_REQ       : one-hot grant, zero when nobody owns the bus
//   pad_out   out WIDTH         : owner's data (combinational from req_data)
//   pad_oe    out WIDTH         : all-ones while granted, otherwise zero
//   busy      out 1             : FSM is not IDLE
// -----------------------------------------------------------------------------
module pad_arbiter
  import pad_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]           pad_out,
  output logic [WIDTH-1:0]           pad_oe,
  output logic                       busy
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last_owner;
  logic [CNT_W-1:0] r_hold_cnt;

  logic             w_any;
  logic [IDX_W-1:0] w_pick;
  logic             w_release;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .last_owner (r_last_owner),
    .any        (w_any),
    .pick       (w_pick)
  );

  // Ownership ends when the owner lets go or has used its full hold budget.
  assign w_release = !req[r_owner] || (r_hold_cnt == CNT_W'(MAX_HOLD));

  // last_owner resets to NUM_REQ-1 so the first search starts at requester 0.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_hold_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state    <= GRANT;
            r_owner    <= w_pick;
            r_hold_cnt <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state      <= TURN;
            r_last_owner <= r_owner;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        TURN: begin
          // Requests that arrive during TURN are served without passing
          // through IDLE.
          if (w_any) begin
            r_state    <= GRANT;
            r_owner    <= w_pick;
            r_hold_cnt <= CNT_W'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  // pad_out remains a combinational path from the owner's req_data.
  always_comb begin
    gnt     = '0;
    pad_oe  = '0;
    pad_out = '0;
    if (r_state == GRANT) begin
      pad_oe = '1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (r_owner == IDX_W'(i)) begin
          gnt[i]  = 1'b1;
          pad_out = req_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule
